// File: rtl/seg_scan_if.sv
// Signal bundle between a host/display driver and seg_scan_ctrl.
// The master drives digit data and display controls; the slave drives the decoder and digit enables.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] din;
    logic                ld;
    logic                lt;
    logic                rbi;
    logic [3:0]          bcd;
    logic                blank;
    logic [DIGITS-1:0]   dig;
    logic                frame;

    modport master (
        output din, ld, lt, rbi,
        input  bcd, blank, dig, frame
    );

    modport slave (
        input  din, ld, lt, rbi,
        output bcd, blank, dig, frame
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode seven-segment display sharing one BCD decoder.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking; otherwise RBI is accepted but ignored.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int DEAD     = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    seg_scan_if.slave scan_io
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_ON
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] staging_q;
    logic [4*DIGITS-1:0] shadow_q;
    logic                pending_q;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                frame_q, frame_d;
    logic                wrapFrame;
    logic [DIGITS-1:0]   blankedVec;
    logic [3:0]          curDigit;
    logic [3:0]          bcdVal;
    logic                blankVal;
    logic                allZero;

    // The first edge after reset only enters slot 0 so FRAME covers a full idx0/cnt0 cycle.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wrapFrame = 1'b0;
        if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d     = '0;
                    wrapFrame = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        state_d = (cnt_d >= CNT_DEAD) ? ST_ON : ST_DEAD;
        frame_d = (idx_d == '0) && (cnt_d == '0);
        dig_d   = (state_d == ST_ON) ? (DIGITS'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            staging_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            dig_q     <= '0;
            frame_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
            if (wrapFrame && pending_q) begin
                shadow_q  <= staging_q;
                pending_q <= 1'b0;
            end
            // A load on the boundary edge overrides the pending clear and waits a frame.
            if (scan_io.ld) begin
                staging_q <= scan_io.din;
                pending_q <= 1'b1;
            end
        end
    end

    always_comb begin
        blankedVec = '0;
        allZero    = 1'b1;
`ifdef SEG_SCAN_LZB_EN
        for (int i = DIGITS - 1; i >= 1; i--) begin
            allZero       = allZero && (shadow_q[4*i +: 4] == 4'h0);
            blankedVec[i] = scan_io.rbi && allZero;
        end
`else
        blankedVec[0] = scan_io.rbi & ~allZero;
`endif
    end

    // LT and RBI act combinationally on the registered slot so their effect is same-cycle.
    always_comb begin
        curDigit = shadow_q[int'(idx_q)*4 +: 4];
        bcdVal   = 4'hF;
        blankVal = 1'b1;
        if (state_q == ST_ON) begin
            if (scan_io.lt) begin
                bcdVal   = 4'h8;
                blankVal = 1'b0;
            end else if (blankedVec[idx_q]) begin
                bcdVal   = 4'hF;
                blankVal = 1'b1;
            end else begin
                bcdVal   = curDigit;
                blankVal = 1'b0;
            end
        end
    end

    assign scan_io.bcd   = bcdVal;
    assign scan_io.blank = blankVal;
    assign scan_io.dig   = dig_q;
    assign scan_io.frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with DIGITS=4, PRESCALE=8, DEAD=2.
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int PRESCALE  = 8;
    localparam int DEAD      = 2;
    localparam int FRAME_LEN = DIGITS * PRESCALE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = -1;

    seg_scan_if #(.DIGITS(DIGITS)) scanIf ();

    seg_scan_ctrl #(
        .DIGITS  (DIGITS),
        .PRESCALE(PRESCALE),
        .DEAD    (DEAD)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .scan_io(scanIf)
    );

    always #5 clk = ~clk;

    // cyc numbers the scan state visible after each edge, 0 = first edge after reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_pos(input int pos);
        for (int k = 0; k < 2 * FRAME_LEN; k++) begin
            if (cyc % FRAME_LEN == pos) return;
            tick();
        end
    endtask

    task automatic test_reset();
        scanIf.din = '0;
        scanIf.ld  = 1'b0;
        scanIf.lt  = 1'b0;
        scanIf.rbi = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (scanIf.dig !== 4'b0000) begin failures++; $display("[TB] FAIL reset_dig: got %b expected 0000", scanIf.dig); end
        checks++; if (scanIf.bcd !== 4'hF) begin failures++; $display("[TB] FAIL reset_bcd: got %h expected f", scanIf.bcd); end
        checks++; if (scanIf.blank !== 1'b1) begin failures++; $display("[TB] FAIL reset_blank: got %b expected 1", scanIf.blank); end
        checks++; if (scanIf.frame !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame: got %b expected 0", scanIf.frame); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
    endtask

    task automatic test_scan_timing();
        int       cnt;
        int       idx;
        logic     on;
        logic [3:0] expDig;
        logic [3:0] expBcd;
        for (int e = 0; e < FRAME_LEN + 8; e++) begin
            tick();
            cnt    = cyc % PRESCALE;
            idx    = (cyc / PRESCALE) % DIGITS;
            on     = (cnt >= DEAD);
            expDig = on ? (4'b0001 << idx) : 4'b0000;
            expBcd = on ? 4'h0 : 4'hF;
            checks++; if (scanIf.dig !== expDig) begin failures++; $display("[TB] FAIL scan_dig cyc=%0d: got %b expected %b", cyc, scanIf.dig, expDig); end
            checks++; if (scanIf.frame !== (cyc % FRAME_LEN == 0)) begin failures++; $display("[TB] FAIL scan_frame cyc=%0d: got %b expected %b", cyc, scanIf.frame, (cyc % FRAME_LEN == 0)); end
            checks++; if (scanIf.bcd !== expBcd) begin failures++; $display("[TB] FAIL scan_bcd cyc=%0d: got %h expected %h", cyc, scanIf.bcd, expBcd); end
            checks++; if (scanIf.blank !== !on) begin failures++; $display("[TB] FAIL scan_blank cyc=%0d: got %b expected %b", cyc, scanIf.blank, !on); end
        end
    endtask

    task automatic test_load_midframe();
        logic [15:0] val;
        val = 16'h1234;
        goto_pos(12);
        scanIf.din = val;
        scanIf.ld  = 1'b1;
        tick();
        scanIf.ld  = 1'b0;
        scanIf.din = '0;
        while (cyc % FRAME_LEN != FRAME_LEN - 1) begin
            tick();
            if (cyc % PRESCALE == 4) begin
                checks++; if (scanIf.bcd !== 4'h0) begin failures++; $display("[TB] FAIL load_old_bcd cyc=%0d: got %h expected 0", cyc, scanIf.bcd); end
            end
        end
        for (int s = 0; s < DIGITS; s++) begin
            goto_pos(s * PRESCALE + 4);
            checks++; if (scanIf.dig !== (4'b0001 << s)) begin failures++; $display("[TB] FAIL load_dig slot=%0d: got %b expected %b", s, scanIf.dig, (4'b0001 << s)); end
            checks++; if (scanIf.bcd !== val[4*s +: 4]) begin failures++; $display("[TB] FAIL load_bcd slot=%0d: got %h expected %h", s, scanIf.bcd, val[4*s +: 4]); end
        end
    endtask

    task automatic test_lzb();
        logic [15:0] expBcd;
        logic [3:0]  expBlank;
`ifdef SEG_SCAN_LZB_EN
        expBcd   = 16'hFF50;
        expBlank = 4'b1100;
`else
        expBcd   = 16'h0050;
        expBlank = 4'b0000;
`endif
        scanIf.rbi = 1'b1;
        scanIf.din = 16'h0050;
        scanIf.ld  = 1'b1;
        tick();
        scanIf.ld  = 1'b0;
        goto_pos(FRAME_LEN - 1);
        for (int s = 0; s < DIGITS; s++) begin
            goto_pos(s * PRESCALE + 4);
            checks++; if (scanIf.dig !== (4'b0001 << s)) begin failures++; $display("[TB] FAIL lzb_dig slot=%0d: got %b expected %b", s, scanIf.dig, (4'b0001 << s)); end
            checks++; if (scanIf.bcd !== expBcd[4*s +: 4]) begin failures++; $display("[TB] FAIL lzb_bcd slot=%0d: got %h expected %h", s, scanIf.bcd, expBcd[4*s +: 4]); end
            checks++; if (scanIf.blank !== expBlank[s]) begin failures++; $display("[TB] FAIL lzb_blank slot=%0d: got %b expected %b", s, scanIf.blank, expBlank[s]); end
        end
        scanIf.rbi = 1'b0;
        #1;
        checks++; if (scanIf.bcd !== 4'h0) begin failures++; $display("[TB] FAIL rbi_release_bcd: got %h expected 0", scanIf.bcd); end
        checks++; if (scanIf.blank !== 1'b0) begin failures++; $display("[TB] FAIL rbi_release_blank: got %b expected 0", scanIf.blank); end
    endtask

    task automatic test_lamp_test();
        int         cnt;
        int         idx;
        logic [3:0] expDig;
        scanIf.din = '0;
        scanIf.ld  = 1'b1;
        tick();
        scanIf.ld  = 1'b0;
        scanIf.rbi = 1'b1;
        goto_pos(FRAME_LEN - 1);
        scanIf.lt = 1'b1;
        #1;
        checks++; if (scanIf.bcd !== 4'h8) begin failures++; $display("[TB] FAIL lt_immediate_bcd: got %h expected 8", scanIf.bcd); end
        for (int e = 0; e < FRAME_LEN; e++) begin
            tick();
            cnt    = cyc % PRESCALE;
            idx    = (cyc / PRESCALE) % DIGITS;
            expDig = (cnt >= DEAD) ? (4'b0001 << idx) : 4'b0000;
            checks++; if (scanIf.dig !== expDig) begin failures++; $display("[TB] FAIL lt_dig cyc=%0d: got %b expected %b", cyc, scanIf.dig, expDig); end
            checks++; if (scanIf.bcd !== ((cnt >= DEAD) ? 4'h8 : 4'hF)) begin failures++; $display("[TB] FAIL lt_bcd cyc=%0d: got %h expected %h", cyc, scanIf.bcd, ((cnt >= DEAD) ? 4'h8 : 4'hF)); end
            checks++; if (scanIf.blank !== (cnt < DEAD)) begin failures++; $display("[TB] FAIL lt_blank cyc=%0d: got %b expected %b", cyc, scanIf.blank, (cnt < DEAD)); end
        end
        scanIf.lt  = 1'b0;
        scanIf.rbi = 1'b0;
    endtask

    task automatic test_boundary_load();
        goto_pos(FRAME_LEN - 1);
        scanIf.din = 16'h9999;
        scanIf.ld  = 1'b1;
        tick();
        scanIf.ld  = 1'b0;
        scanIf.din = '0;
        for (int s = 0; s < DIGITS; s++) begin
            goto_pos(s * PRESCALE + 4);
            checks++; if (scanIf.bcd !== 4'h0) begin failures++; $display("[TB] FAIL boundary_hold_bcd slot=%0d: got %h expected 0", s, scanIf.bcd); end
        end
        for (int s = 0; s < DIGITS; s++) begin
            goto_pos(s * PRESCALE + 4);
            checks++; if (scanIf.bcd !== 4'h9) begin failures++; $display("[TB] FAIL boundary_apply_bcd slot=%0d: got %h expected 9", s, scanIf.bcd); end
        end
    endtask

    task automatic test_back_to_back();
        goto_pos(5);
        scanIf.din = 16'h1111;
        scanIf.ld  = 1'b1;
        tick();
        scanIf.din = 16'h2222;
        tick();
        scanIf.ld  = 1'b0;
        scanIf.din = '0;
        goto_pos(PRESCALE + 4);
        checks++; if (scanIf.bcd !== 4'h9) begin failures++; $display("[TB] FAIL b2b_hold_bcd: got %h expected 9", scanIf.bcd); end
        for (int s = 0; s < DIGITS; s++) begin
            goto_pos(s * PRESCALE + 4);
            checks++; if (scanIf.bcd !== 4'h2) begin failures++; $display("[TB] FAIL b2b_last_wins slot=%0d: got %h expected 2", s, scanIf.bcd); end
        end
    endtask

    task automatic test_reset_mid();
        goto_pos(2 * PRESCALE + 4);
        checks++; if (scanIf.dig !== 4'b0100) begin failures++; $display("[TB] FAIL pre_reset_dig: got %b expected 0100", scanIf.dig); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (scanIf.dig !== 4'b0000) begin failures++; $display("[TB] FAIL mid_reset_dig: got %b expected 0000", scanIf.dig); end
        checks++; if (scanIf.bcd !== 4'hF) begin failures++; $display("[TB] FAIL mid_reset_bcd: got %h expected f", scanIf.bcd); end
        checks++; if (scanIf.blank !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_blank: got %b expected 1", scanIf.blank); end
        checks++; if (scanIf.frame !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_frame: got %b expected 0", scanIf.frame); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
        tick();
        checks++; if (scanIf.frame !== 1'b1) begin failures++; $display("[TB] FAIL restart_frame: got %b expected 1", scanIf.frame); end
        checks++; if (scanIf.dig !== 4'b0000) begin failures++; $display("[TB] FAIL restart_dead_dig: got %b expected 0000", scanIf.dig); end
        tick();
        tick();
        checks++; if (scanIf.dig !== 4'b0001) begin failures++; $display("[TB] FAIL restart_dig: got %b expected 0001", scanIf.dig); end
        checks++; if (scanIf.bcd !== 4'h0) begin failures++; $display("[TB] FAIL restart_shadow_bcd: got %h expected 0", scanIf.bcd); end
        checks++; if (scanIf.blank !== 1'b0) begin failures++; $display("[TB] FAIL restart_blank: got %b expected 0", scanIf.blank); end
        checks++; if (scanIf.frame !== 1'b0) begin failures++; $display("[TB] FAIL restart_frame_low: got %b expected 0", scanIf.frame); end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_load_midframe();
        test_lzb();
        test_lamp_test();
        test_boundary_load();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
